// File: rtl/ollar_pkg.sv
// Shared constants for the OLLAR memory-port arbiter: requester indices,
// FSM state encoding and watchdog counter width.
package ollar_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_LS   = 0;
  localparam int REQ_OPT  = 1;
  localparam int REQ_IF   = 2;
  localparam int WD_CNT_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ollar_arb_prio.sv
// Fixed-priority encoder (ld/st > option fetch > instr fetch) producing a
// one-hot grant; a flush masks both fetch requesters for the cycle.
module ollar_arb_prio
  import ollar_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               flush,
  output logic [NUM_REQ-1:0] gnt
);

  logic [NUM_REQ-1:0] req_m;

  always_comb begin
    req_m          = req;
    req_m[REQ_OPT] = req[REQ_OPT] & ~flush;
    req_m[REQ_IF]  = req[REQ_IF] & ~flush;
    gnt            = '0;
    if (req_m[REQ_LS])
      gnt[REQ_LS] = 1'b1;
    else if (req_m[REQ_OPT])
      gnt[REQ_OPT] = 1'b1;
    else if (req_m[REQ_IF])
      gnt[REQ_IF] = 1'b1;
  end

endmodule

// File: rtl/ollar_mem_arbiter.sv
// Single-port memory arbiter for the OLLAR pipeline requesters.
// Optional access watchdog enabled by defining OLLAR_ARB_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate pending requests
// ACCESS | access issued to memory; wait for mem_ready
module ollar_mem_arbiter
  import ollar_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  Reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  we_ls,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [DW-1:0]         wdata_ls,
  input  logic                  flush,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  input  logic                  mem_ready,
  output logic                  bus_err
);

  if (TIMEOUT < 1 || TIMEOUT > (1 << WD_CNT_W) - 1) begin : g_bad_timeout
    $error("ollar_mem_arbiter: TIMEOUT out of range for watchdog counter");
  end

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] prio_gnt;
  logic [NUM_REQ-1:0] win, win_nxt;
  logic               flushed, flushed_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
  logic [DW-1:0]      rdata_nxt;
  logic               busy_nxt, mem_req_nxt, mem_we_nxt;
  logic [AW-1:0]      mem_addr_nxt, sel_addr;
  logic [DW-1:0]      mem_wdata_nxt;
  logic               flush_hit, finish;

  ollar_arb_prio u_prio (
    .req   (req),
    .flush (flush),
    .gnt   (prio_gnt)
  );

`ifdef OLLAR_ARB_WATCHDOG_EN
  localparam logic [WD_CNT_W-1:0] WD_LIMIT = WD_CNT_W'(TIMEOUT - 1);
  logic [WD_CNT_W-1:0] wd_cnt, wd_cnt_nxt;
  logic                bus_err_nxt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      win       <= '0;
      flushed   <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef OLLAR_ARB_WATCHDOG_EN
      wd_cnt    <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      win       <= win_nxt;
      flushed   <= flushed_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      rdata     <= rdata_nxt;
      busy      <= busy_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
`ifdef OLLAR_ARB_WATCHDOG_EN
      wd_cnt    <= wd_cnt_nxt;
      bus_err   <= bus_err_nxt;
`endif
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (prio_gnt[i]) sel_addr = addr[i*AW +: AW];
  end

  always_comb begin
    state_nxt     = state;
    win_nxt       = win;
    flushed_nxt   = flushed;
    gnt_nxt       = '0;
    done_nxt      = '0;
    rdata_nxt     = '0;
    busy_nxt      = busy;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    flush_hit     = 1'b0;
    finish        = 1'b0;
`ifdef OLLAR_ARB_WATCHDOG_EN
    wd_cnt_nxt    = wd_cnt;
    bus_err_nxt   = bus_err;
`endif
    unique case (state)
      IDLE: begin
        if (|prio_gnt) begin
          state_nxt     = ACCESS;
          win_nxt       = prio_gnt;
          flushed_nxt   = 1'b0;
          gnt_nxt       = prio_gnt;
          busy_nxt      = 1'b1;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = prio_gnt[REQ_LS] & we_ls;
          mem_addr_nxt  = sel_addr;
          mem_wdata_nxt = prio_gnt[REQ_LS] ? wdata_ls : '0;
`ifdef OLLAR_ARB_WATCHDOG_EN
          wd_cnt_nxt    = '0;
`endif
        end
      end
      ACCESS: begin
        // A flush seen at any point of a fetch access kills its result;
        // stores and loads from the ld/st port are never cancelled.
        flush_hit   = flushed | (flush & ~win[REQ_LS]);
        flushed_nxt = flush_hit;
        finish      = mem_ready;
`ifdef OLLAR_ARB_WATCHDOG_EN
        if (!mem_ready) begin
          if (wd_cnt == WD_LIMIT) begin
            finish      = 1'b1;
            bus_err_nxt = 1'b1;
          end else begin
            wd_cnt_nxt = wd_cnt + 1'b1;
          end
        end
`endif
        if (finish) begin
          state_nxt   = IDLE;
          busy_nxt    = 1'b0;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          done_nxt    = flush_hit ? '0 : win;
          rdata_nxt   = (mem_ready && !mem_we && !flush_hit) ? mem_rdata : '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ollar_mem_arbiter.sv
// Self-checking bench for ollar_mem_arbiter: vector table plus hand-written
// flush/reset/watchdog sequences, with a done/rdata scoreboard.
module tb_ollar_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          Reset_n = 1'b1;
  logic [2:0]    req = '0;
  logic          we_ls = 1'b0;
  logic [95:0]   addr = '0;
  logic [31:0]   wdata_ls = '0;
  logic          flush = 1'b0;
  logic [2:0]    gnt, done;
  logic [31:0]   rdata;
  logic          busy, mem_req, mem_we, bus_err;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mem_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int stall_cfg = 0;
  int seen = 0;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    int          stall;
    logic [2:0]  exp_gnt;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [2:0]  done;
    logic [31:0] rdata;
  } exp_t;

  vec_t tbl[6];
  vec_t t;
  exp_t sb_q[$];
  exp_t mon_e;

  ollar_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clock     (clock),
    .Reset_n   (Reset_n),
    .req       (req),
    .we_ls     (we_ls),
    .addr      (addr),
    .wdata_ls  (wdata_ls),
    .flush     (flush),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .bus_err   (bus_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = mem_req ? mem_fn(mem_addr) : 32'h0;

  // Memory responder: ready after stall_cfg access cycles with ready low.
  always @(negedge clock) begin
    if (mem_req) begin
      mem_ready = (seen >= stall_cfg);
      seen++;
    end else begin
      mem_ready = 1'b0;
      seen = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (Reset_n && done != 3'b000) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done: got done=%b rdata=%h expected no completion", done, rdata);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_done", {29'b0, done}, {29'b0, mon_e.done});
        chk("sb_rdata", rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    tbl[0] = '{idx:2, we:1'b0, a:32'h0000_0040, wd:32'h0, stall:0,
               exp_gnt:3'b100, exp_we:1'b0, exp_wdata:32'h0, exp_rdata:mem_fn(32'h0000_0040)};
    tbl[1] = '{idx:0, we:1'b1, a:32'h0000_0010, wd:32'hDEAD_BEEF, stall:3,
               exp_gnt:3'b001, exp_we:1'b1, exp_wdata:32'hDEAD_BEEF, exp_rdata:32'h0};
    tbl[2] = '{idx:1, we:1'b0, a:32'h1234_5678, wd:32'h0, stall:1,
               exp_gnt:3'b010, exp_we:1'b0, exp_wdata:32'h0, exp_rdata:mem_fn(32'h1234_5678)};
    tbl[3] = '{idx:0, we:1'b0, a:32'hFFFF_FFFC, wd:32'hCAFE_0000, stall:0,
               exp_gnt:3'b001, exp_we:1'b0, exp_wdata:32'hCAFE_0000, exp_rdata:mem_fn(32'hFFFF_FFFC)};
    tbl[4] = '{idx:2, we:1'b1, a:32'h0000_0080, wd:32'h1111_2222, stall:2,
               exp_gnt:3'b100, exp_we:1'b0, exp_wdata:32'h0, exp_rdata:mem_fn(32'h0000_0080)};
    tbl[5] = '{idx:0, we:1'b1, a:32'hFFFF_FFFF, wd:32'h0000_0001, stall:0,
               exp_gnt:3'b001, exp_we:1'b1, exp_wdata:32'h0000_0001, exp_rdata:32'h0};

    #2 Reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ctrl", {23'b0, gnt, done, busy, mem_req, mem_we, bus_err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    Reset_n = 1'b1;
    tick();

    // Table-driven single accesses
    for (int v = 0; v < 6; v++) begin
      t = tbl[v];
      stall_cfg = t.stall;
      req = 3'b000;
      req[t.idx] = 1'b1;
      addr[t.idx*32 +: 32] = t.a;
      we_ls = t.we;
      wdata_ls = t.wd;
      tick();
      chk("vec_gnt", {29'b0, gnt}, {29'b0, t.exp_gnt});
      chk("vec_issue", {29'b0, busy, mem_req, mem_we}, {29'b0, 1'b1, 1'b1, t.exp_we});
      chk("vec_mem_addr", mem_addr, t.a);
      chk("vec_mem_wdata", mem_wdata, t.exp_wdata);
      sb_q.push_back('{done: t.exp_gnt, rdata: t.exp_rdata});
      for (int k = 0; k < t.stall; k++) begin
        tick();
        chk("vec_hold", {23'b0, mem_req, busy, mem_we, gnt, done},
            {23'b0, 1'b1, 1'b1, t.exp_we, 3'b000, 3'b000});
        chk("vec_hold_addr", mem_addr, t.a);
        chk("vec_hold_wdata", mem_wdata, t.exp_wdata);
      end
      tick();
      chk("vec_done", {29'b0, done}, {29'b0, t.exp_gnt});
      chk("vec_busy_drop", {30'b0, busy, mem_req}, 32'h0);
      req = 3'b000;
      we_ls = 1'b0;
      tick();
      chk("vec_done_pulse", {29'b0, done}, 32'h0);
    end

    // All three at once: served r0, r1, r2, two cycles apart
    stall_cfg = 0;
    req = 3'b111;
    addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("all_gnt", {29'b0, gnt}, 32'(1 << k));
      chk("all_addr", mem_addr, 32'h100 * (k + 1));
      sb_q.push_back('{done: 3'(1 << k), rdata: mem_fn(32'h100 * (k + 1))});
      tick();
      chk("all_done", {29'b0, done}, 32'(1 << k));
      req[k] = 1'b0;
    end
    tick();
    chk("all_idle", {26'b0, busy, gnt, done}, 32'h0);

    // Fetch in flight flushed; pending r0 granted afterwards
    stall_cfg = 2;
    req = 3'b100;
    addr[64 +: 32] = 32'h0000_0400;
    tick();
    chk("fl_gnt", {29'b0, gnt}, 32'b100);
    flush = 1'b1;
    req[0] = 1'b1;
    addr[31:0] = 32'h0000_0020;
    tick();
    flush = 1'b0;
    req[2] = 1'b0;
    chk("fl_busy_held", {31'b0, busy}, 32'h1);
    tick();
    tick();
    chk("fl_done_supp", {29'b0, done}, 32'h0);
    chk("fl_rdata_zero", rdata, 32'h0);
    chk("fl_busy_drop", {31'b0, busy}, 32'h0);
    stall_cfg = 0;
    tick();
    chk("fl_r0_gnt", {29'b0, gnt}, 32'b001);
    chk("fl_r0_addr", mem_addr, 32'h0000_0020);
    sb_q.push_back('{done: 3'b001, rdata: mem_fn(32'h0000_0020)});
    tick();
    chk("fl_r0_done", {29'b0, done}, 32'b001);
    req = 3'b000;
    tick();

    // Flush in the same cycle as mem_ready
    req = 3'b010;
    addr[32 +: 32] = 32'h0000_0088;
    tick();
    chk("flr_gnt", {29'b0, gnt}, 32'b010);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req = 3'b000;
    chk("flr_done_supp", {29'b0, done}, 32'h0);
    chk("flr_rdata_zero", rdata, 32'h0);
    chk("flr_busy_drop", {31'b0, busy}, 32'h0);
    tick();

    // Flush in IDLE masks fetch requests for that cycle only
    req = 3'b010;
    addr[32 +: 32] = 32'h0000_0090;
    flush = 1'b1;
    tick();
    chk("fli_masked", {28'b0, busy, gnt}, 32'h0);
    flush = 1'b0;
    tick();
    chk("fli_gnt", {29'b0, gnt}, 32'b010);
    sb_q.push_back('{done: 3'b010, rdata: mem_fn(32'h0000_0090)});
    tick();
    chk("fli_done", {29'b0, done}, 32'b010);
    req = 3'b000;
    tick();

    // Flush never cancels r0
    stall_cfg = 1;
    req = 3'b001;
    addr[31:0] = 32'h0000_0024;
    flush = 1'b1;
    tick();
    chk("fl0_gnt", {29'b0, gnt}, 32'b001);
    sb_q.push_back('{done: 3'b001, rdata: mem_fn(32'h0000_0024)});
    tick();
    tick();
    chk("fl0_done", {29'b0, done}, 32'b001);
    flush = 1'b0;
    req = 3'b000;
    tick();

    // Reset mid-access clears outputs without waiting for an edge
    stall_cfg = 10;
    req = 3'b100;
    addr[64 +: 32] = 32'h0000_0600;
    tick();
    chk("rsm_gnt", {29'b0, gnt}, 32'b100);
    Reset_n = 1'b0;
    #1;
    chk("rsm_async", {27'b0, gnt, busy, mem_req}, 32'h0);
    req = 3'b000;
    stall_cfg = 0;
    tick();
    Reset_n = 1'b1;
    req = 3'b010;
    addr[32 +: 32] = 32'h0000_0700;
    tick();
    chk("rsm_post_gnt", {29'b0, gnt}, 32'b010);
    sb_q.push_back('{done: 3'b010, rdata: mem_fn(32'h0000_0700)});
    tick();
    chk("rsm_post_done", {29'b0, done}, 32'b010);
    req = 3'b000;
    tick();

`ifdef OLLAR_ARB_WATCHDOG_EN
    stall_cfg = 1000;
    req = 3'b100;
    addr[64 +: 32] = 32'h0000_0500;
    tick();
    chk("wd_gnt", {29'b0, gnt}, 32'b100);
    sb_q.push_back('{done: 3'b100, rdata: 32'h0});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wd_wait", {28'b0, busy, done}, 32'b1000);
    end
    tick();
    chk("wd_done", {29'b0, done}, 32'b100);
    chk("wd_bus_err", {31'b0, bus_err}, 32'h1);
    chk("wd_busy_drop", {31'b0, busy}, 32'h0);
    req = 3'b000;
    stall_cfg = 0;
    tick();
    tick();
    chk("wd_sticky", {31'b0, bus_err}, 32'h1);
    Reset_n = 1'b0;
    #1;
    chk("wd_rst_clear", {31'b0, bus_err}, 32'h0);
    tick();
    Reset_n = 1'b1;
    tick();
`else
    chk("bus_err_tied", {31'b0, bus_err}, 32'h0);
`endif

    tick();
    chk("sb_empty", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
